sd_block_server: RTL and testbench



---
 rtl/sd_block_server.sv | 207 ++++++++++++++++++++
 tb/tb_sd_block_server.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_server.sv
// rtl/sd_block_server.sv - virtual-disk sector responder moving 512-byte sectors to/from a byte-wide memory port
module sd_block_server #(
   parameter int VDNUM     = 3,
   parameter int ACK_DELAY = 4
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic [32*VDNUM-1:0]  sd_lba,
   input  logic [VDNUM-1:0]     sd_rd,
   input  logic [VDNUM-1:0]     sd_wr,
   output logic [VDNUM-1:0]     sd_ack,
   output logic [8:0]           sd_buff_addr,
   output logic [7:0]           sd_buff_dout,
   input  logic [8*VDNUM-1:0]   sd_buff_din,
   output logic                 sd_buff_wr,
   output logic [31:0]          mem_addr,
   output logic [1:0]           mem_drive,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [7:0]           mem_din,
   input  logic [7:0]           mem_dout,
   input  logic                 mem_ready,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE, WAIT, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE
   } state_t;

   state_t             state, state_n;
   logic [1:0]         drive, drive_n;
   logic [22:0]        lba, lba_n;
   logic               is_wr, is_wr_n;
   logic [8:0]         idx, idx_n;
   logic [7:0]         cnt, cnt_n;

   logic [VDNUM-1:0]   ack_n;
   logic [8:0]         buff_addr_n;
   logic [7:0]         buff_dout_n;
   logic               buff_wr_n;
   logic [31:0]        mem_addr_n;
   logic [1:0]         mem_drive_n;
   logic               mem_rd_n, mem_wr_n, busy_n;
   logic [7:0]         mem_din_n;

   logic               found, sel_rd;
   logic [1:0]         sel;
   logic [22:0]        sel_lba;
   logic [7:0]         din_sel;
   logic               unused_lba;

   // Request arbitration (lowest index wins) and write-data slot selection
   always_comb begin
      found      = 1'b0;
      sel        = 2'd0;
      sel_lba    = 23'd0;
      sel_rd     = 1'b0;
      din_sel    = 8'd0;
      unused_lba = 1'b0;
      for (int d = VDNUM - 1; d >= 0; d--) begin
         unused_lba = unused_lba ^ (^sd_lba[32*d+23 +: 9]);
         if (sd_rd[d] | sd_wr[d]) begin
            found   = 1'b1;
            sel     = 2'(d);
            sel_lba = sd_lba[32*d +: 23];
            sel_rd  = sd_rd[d];
         end
      end
      for (int d = 0; d < VDNUM; d++) begin
         if (drive == 2'(d)) din_sel = sd_buff_din[8*d +: 8];
      end
   end

   // Next-state and next-output logic; every output is registered from these values
   always_comb begin
      state_n     = state;
      drive_n     = drive;
      lba_n       = lba;
      is_wr_n     = is_wr;
      idx_n       = idx;
      cnt_n       = cnt;
      ack_n       = sd_ack;
      buff_addr_n = sd_buff_addr;
      buff_dout_n = sd_buff_dout;
      buff_wr_n   = 1'b0;
      mem_addr_n  = mem_addr;
      mem_drive_n = mem_drive;
      mem_rd_n    = mem_rd;
      mem_wr_n    = mem_wr;
      mem_din_n   = mem_din;
      case (state)
         IDLE: begin
            if (found) begin
               drive_n     = sel;
               mem_drive_n = sel;
               lba_n       = sel_lba;
               is_wr_n     = ~sel_rd;
               idx_n       = 9'd0;
               cnt_n       = 8'd0;
               state_n     = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 8'(ACK_DELAY - 1)) begin
               for (int d = 0; d < VDNUM; d++) ack_n[d] = (drive == 2'(d));
               if (is_wr) begin
                  buff_addr_n = idx;
                  state_n     = WR_ADDR;
               end else begin
                  mem_rd_n   = 1'b1;
                  mem_addr_n = {lba, idx};
                  state_n    = RD_REQ;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         RD_REQ: begin
            if (mem_ready) begin
               mem_rd_n    = 1'b0;
               buff_dout_n = mem_dout;
               buff_addr_n = idx;
               buff_wr_n   = 1'b1;
               state_n     = RD_PUT;
            end
         end
         RD_PUT: begin
            if (idx == 9'd511) begin
               ack_n   = '0;
               state_n = DONE;
            end else begin
               idx_n      = idx + 9'd1;
               mem_rd_n   = 1'b1;
               mem_addr_n = {lba, idx + 9'd1};
               state_n    = RD_REQ;
            end
         end
         WR_ADDR: state_n = WR_CAP;
         WR_CAP: begin
            // requester buffer data for the address presented last cycle is valid now
            mem_din_n  = din_sel;
            mem_wr_n   = 1'b1;
            mem_addr_n = {lba, idx};
            state_n    = WR_MEM;
         end
         WR_MEM: begin
            if (mem_ready) begin
               mem_wr_n = 1'b0;
               if (idx == 9'd511) begin
                  ack_n   = '0;
                  state_n = DONE;
               end else begin
                  idx_n       = idx + 9'd1;
                  buff_addr_n = idx + 9'd1;
                  state_n     = WR_ADDR;
               end
            end
         end
         DONE: begin
            ack_n   = '0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State and output registers with synchronous reset that abandons any transfer
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state        <= IDLE;
         drive        <= 2'd0;
         lba          <= 23'd0;
         is_wr        <= 1'b0;
         idx          <= 9'd0;
         cnt          <= 8'd0;
         sd_ack       <= '0;
         sd_buff_addr <= 9'd0;
         sd_buff_dout <= 8'd0;
         sd_buff_wr   <= 1'b0;
         mem_addr     <= 32'd0;
         mem_drive    <= 2'd0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_din      <= 8'd0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         drive        <= drive_n;
         lba          <= lba_n;
         is_wr        <= is_wr_n;
         idx          <= idx_n;
         cnt          <= cnt_n;
         sd_ack       <= ack_n;
         sd_buff_addr <= buff_addr_n;
         sd_buff_dout <= buff_dout_n;
         sd_buff_wr   <= buff_wr_n;
         mem_addr     <= mem_addr_n;
         mem_drive    <= mem_drive_n;
         mem_rd       <= mem_rd_n;
         mem_wr       <= mem_wr_n;
         mem_din      <= mem_din_n;
         busy         <= busy_n;
      end
   end

endmodule

// File: tb/tb_sd_block_server.sv
// tb/tb_sd_block_server.sv - scoreboard bench for sd_block_server
module tb_sd_block_server;
   localparam int VDNUM     = 3;
   localparam int ACK_DELAY = 4;

   logic                clk_sys = 1'b0;
   logic                reset;
   logic [32*VDNUM-1:0] sd_lba;
   logic [VDNUM-1:0]    sd_rd, sd_wr, sd_ack;
   logic [8:0]          sd_buff_addr;
   logic [7:0]          sd_buff_dout;
   logic [8*VDNUM-1:0]  sd_buff_din;
   logic                sd_buff_wr;
   logic [31:0]         mem_addr;
   logic [1:0]          mem_drive;
   logic                mem_rd, mem_wr, mem_ready, busy;
   logic [7:0]          mem_din, mem_dout;

   always #5 clk_sys = ~clk_sys;

   sd_block_server #(.VDNUM(VDNUM), .ACK_DELAY(ACK_DELAY)) dut (
      .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
      .mem_drive(mem_drive), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy));

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
      logic        wr;
      logic [1:0]  drive;
   } mem_exp_t;
   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] data;
   } buf_exp_t;

   mem_exp_t mem_q[$];
   buf_exp_t buf_q[$];
   mem_exp_t me;
   buf_exp_t be;
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] buf_byte(input int d, input logic [8:0] i);
      return (d == 2) ? i[7:0] : (i[7:0] ^ (8'h30 + 8'(d)));
   endfunction

   // requester buffers: 1-cycle read latency on sd_buff_addr
   logic [8:0] last_addr = 9'd0;
   always @(negedge clk_sys) begin
      for (int d = 0; d < VDNUM; d++) sd_buff_din[8*d +: 8] = buf_byte(d, last_addr);
      last_addr = sd_buff_addr;
   end

   // memory model plus output monitor
   bit          stall_en = 0;
   bit          stall_armed = 0;
   int          stall_left = 0;
   bit          prev_pending = 0;
   logic        prev_rd, prev_wr;
   logic [31:0] prev_addr;
   logic [1:0]  prev_drive;
   logic [7:0]  prev_din;
   logic [VDNUM-1:0] prev_ack = '0;
   int          cyc = 0;
   int          fall_cyc = 0;
   bit          fall_seen = 0;

   always @(negedge clk_sys) begin
      cyc++;
      if (!reset) begin
         check("ack_onehot", 64'($countones(sd_ack) <= 1), 64'd1);
         check("rd_wr_exclusive", {63'd0, mem_rd & mem_wr}, 64'd0);
         if (sd_buff_wr) begin
            check("buff_wr_in_ack", {63'd0, |sd_ack}, 64'd1);
            check("buff_wr_vs_mem_rd", {63'd0, mem_rd}, 64'd0);
            check("buff_wr_expected", 64'(buf_q.size() > 0), 64'd1);
            if (buf_q.size() > 0) begin
               be = buf_q.pop_front();
               check("buff_addr", 64'(sd_buff_addr), 64'(be.addr));
               check("buff_dout", 64'(sd_buff_dout), 64'(be.data));
            end
         end
         if (prev_pending) begin
            check("strobe_held", {62'd0, mem_rd, mem_wr}, {62'd0, prev_rd, prev_wr});
            check("addr_held", 64'(mem_addr), 64'(prev_addr));
            check("drive_held", 64'(mem_drive), 64'(prev_drive));
            if (prev_wr) check("din_held", 64'(mem_din), 64'(prev_din));
         end
         if (sd_ack != '0 && prev_ack == '0 && fall_seen)
            check("ack_gap", 64'((cyc - fall_cyc) >= 2), 64'd1);
      end
      if (sd_ack == '0 && prev_ack != '0) begin
         fall_seen = 1;
         fall_cyc  = cyc;
      end
      prev_ack = sd_ack;

      if (mem_rd | mem_wr) begin
         if (!stall_armed) begin
            stall_armed = 1;
            stall_left  = stall_en ? int'($urandom_range(0, 5)) : 0;
         end
         if (stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
         end else begin
            mem_ready   = 1'b1;
            stall_armed = 0;
         end
      end else begin
         mem_ready   = 1'b0;
         stall_armed = 0;
      end
      mem_dout = mem_addr[7:0] ^ 8'h5A;

      if ((mem_rd | mem_wr) && mem_ready && !reset) begin
         check("mem_expected", 64'(mem_q.size() > 0), 64'd1);
         if (mem_q.size() > 0) begin
            me = mem_q.pop_front();
            check("mem_addr", 64'(mem_addr), 64'(me.addr));
            check("mem_drive", 64'(mem_drive), 64'(me.drive));
            check("mem_dir", {63'd0, mem_wr}, {63'd0, me.wr});
            if (me.wr) check("mem_din", 64'(mem_din), 64'(me.data));
         end
      end
      prev_pending = (mem_rd | mem_wr) && !mem_ready;
      prev_rd      = mem_rd;
      prev_wr      = mem_wr;
      prev_addr    = mem_addr;
      prev_drive   = mem_drive;
      prev_din     = mem_din;
   end

   task automatic cyc1();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic push_read(input int d, input logic [31:0] lba);
      for (int i = 0; i < 512; i++) begin
         mem_q.push_back({{lba[22:0], 9'(i)}, 8'h00, 1'b0, 2'(d)});
         buf_q.push_back({9'(i), 8'(i) ^ 8'h5A});
      end
   endtask

   task automatic push_write(input int d, input logic [31:0] lba);
      for (int i = 0; i < 512; i++)
         mem_q.push_back({{lba[22:0], 9'(i)}, buf_byte(d, 9'(i)), 1'b1, 2'(d)});
   endtask

   task automatic wait_ack(input int d, output int n);
      n = 0;
      do begin
         cyc1();
         n++;
      end while (!sd_ack[d] && n < 6000);
      check("ack_rise_in_time", {63'd0, sd_ack[d]}, 64'd1);
   endtask

   task automatic wait_fall(input int d, output int n);
      n = 1;
      forever begin
         cyc1();
         if (!sd_ack[d] || n > 6000) break;
         n++;
      end
      check("ack_fall_in_time", {63'd0, sd_ack[d]}, 64'd0);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_mem_q_empty"}, 64'(mem_q.size()), 64'd0);
      check({tag, "_buf_q_empty"}, 64'(buf_q.size()), 64'd0);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      sd_lba = '0;
      sd_rd = '0;
      sd_wr = '0;
      mem_ready = 1'b0;
      mem_dout = 8'd0;
      repeat (4) cyc1();
      check("rst_ack", 64'(sd_ack), 64'd0);
      check("rst_buff_addr", 64'(sd_buff_addr), 64'd0);
      check("rst_buff_dout", 64'(sd_buff_dout), 64'd0);
      check("rst_buff_wr", {63'd0, sd_buff_wr}, 64'd0);
      check("rst_mem_rd", {63'd0, mem_rd}, 64'd0);
      check("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_din", 64'(mem_din), 64'd0);
      check("rst_mem_drive", 64'(mem_drive), 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      reset = 1'b0;
      cyc1();

      // read, drive 1, lba 5
      sd_lba[32*1 +: 32] = 32'd5;
      push_read(1, 32'd5);
      sd_rd[1] = 1'b1;
      wait_ack(1, n);
      check("rd_ack_latency", 64'(n), 64'(ACK_DELAY + 1));
      sd_rd[1] = 1'b0;
      wait_fall(1, n);
      check("rd_ack_len", 64'(n), 64'd1024);
      check_drained("rd1");
      repeat (3) cyc1();

      // write, drive 2, lba 0x10
      sd_lba[32*2 +: 32] = 32'h10;
      push_write(2, 32'h10);
      sd_wr[2] = 1'b1;
      wait_ack(2, n);
      check("wr_ack_latency", 64'(n), 64'(ACK_DELAY + 1));
      sd_wr[2] = 1'b0;
      wait_fall(2, n);
      check("wr_ack_len", 64'(n), 64'd1536);
      check_drained("wr2");
      repeat (3) cyc1();

      // simultaneous reads on drives 0 and 2
      sd_lba[32*0 +: 32] = 32'h20;
      sd_lba[32*2 +: 32] = 32'h30;
      push_read(0, 32'h20);
      push_read(2, 32'h30);
      sd_rd[0] = 1'b1;
      sd_rd[2] = 1'b1;
      wait_ack(0, n);
      check("sim_ack0_latency", 64'(n), 64'(ACK_DELAY + 1));
      check("sim_ack2_low", {63'd0, sd_ack[2]}, 64'd0);
      sd_rd[0] = 1'b0;
      wait_fall(0, n);
      wait_ack(2, n);
      check("sim_ack2_after_fall", 64'(n), 64'(ACK_DELAY + 2));
      sd_rd[2] = 1'b0;
      wait_fall(2, n);
      check_drained("sim");
      repeat (3) cyc1();

      // random memory stalls on a read and a write
      stall_en = 1;
      sd_lba[32*1 +: 32] = 32'h7;
      push_read(1, 32'h7);
      sd_rd[1] = 1'b1;
      wait_ack(1, n);
      sd_rd[1] = 1'b0;
      wait_fall(1, n);
      check("stall_rd_longer", 64'(n >= 1024), 64'd1);
      check_drained("stall_rd");
      repeat (3) cyc1();
      sd_lba[32*2 +: 32] = 32'h33;
      push_write(2, 32'h33);
      sd_wr[2] = 1'b1;
      wait_ack(2, n);
      sd_wr[2] = 1'b0;
      wait_fall(2, n);
      check_drained("stall_wr");
      stall_en = 0;
      repeat (3) cyc1();

      // reset at byte 200 of a read, then a full re-issued read
      sd_lba[32*0 +: 32] = 32'h44;
      push_read(0, 32'h44);
      sd_rd[0] = 1'b1;
      wait_ack(0, n);
      sd_rd[0] = 1'b0;
      n = 0;
      while (!(sd_buff_wr && sd_buff_addr == 9'd200) && n < 2000) begin
         cyc1();
         n++;
      end
      check("reached_byte200", {63'd0, sd_buff_wr && sd_buff_addr == 9'd200}, 64'd1);
      reset = 1'b1;
      cyc1();
      check("mid_rst_ack", 64'(sd_ack), 64'd0);
      check("mid_rst_mem_rd", {63'd0, mem_rd}, 64'd0);
      check("mid_rst_buff_wr", {63'd0, sd_buff_wr}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      reset = 1'b0;
      mem_q.delete();
      buf_q.delete();
      cyc1();
      push_read(0, 32'h44);
      sd_rd[0] = 1'b1;
      wait_ack(0, n);
      check("rerd_ack_latency", 64'(n), 64'(ACK_DELAY + 1));
      sd_rd[0] = 1'b0;
      wait_fall(0, n);
      check("rerd_ack_len", 64'(n), 64'd1024);
      check_drained("rerd");
      repeat (3) cyc1();

      // read and write both requested on drive 0: read first, then the held write
      sd_lba[32*0 +: 32] = 32'h55;
      push_read(0, 32'h55);
      push_write(0, 32'h55);
      sd_rd[0] = 1'b1;
      sd_wr[0] = 1'b1;
      wait_ack(0, n);
      sd_rd[0] = 1'b0;
      wait_fall(0, n);
      check("rw_first_len", 64'(n), 64'd1024);
      check("rw_read_done_buf", 64'(buf_q.size()), 64'd0);
      wait_ack(0, n);
      check("rw_second_latency", 64'(n), 64'(ACK_DELAY + 2));
      sd_wr[0] = 1'b0;
      wait_fall(0, n);
      check("rw_second_len", 64'(n), 64'd1536);
      check_drained("rw");
      repeat (3) cyc1();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
